waveform_sequencer: RTL and testbench

WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

---
 rtl/waveform_sequencer_if.sv | 41 ++++
 rtl/waveform_sequencer.sv | 172 +++++++++++++++++
 tb/tb_waveform_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_sequencer_if.sv
// Bundle of control, waveform-LUT, pixel-buffer and source-driver signals
// between the waveform sequencer (master) and its environment (slave).
interface waveform_sequencer_if #(
    parameter int AW = 17
) ();
    // valid/ready: a transfer happens on a cycle where both are high; the
    // sender keeps its payload stable from the first valid cycle until then.
    logic          start;
    logic          abort;
    logic [1:0]    phase_type;
    logic          busy;
    logic          done;
    logic [6:0]    wf_phase;
    logic [1:0]    wf_phase_type;
    logic [6:0]    wf_phase_count;
    logic [15:0]   wf_data_in;
    logic [7:0]    wf_data_out;
    logic          pix_req;
    logic [AW-1:0] pix_addr;
    logic          pix_valid;
    logic [15:0]   pix_data;
    logic          src_valid;
    logic [7:0]    src_data;
    logic          src_ready;
    logic          frame_start;
    logic          line_start;

    modport master (
        input  start, abort, phase_type, wf_phase_count, wf_data_out,
               pix_valid, pix_data, src_ready,
        output busy, done, wf_phase, wf_phase_type, wf_data_in,
               pix_req, pix_addr, src_valid, src_data, frame_start, line_start
    );

    modport slave (
        output start, abort, phase_type, wf_phase_count, wf_data_out,
               pix_valid, pix_data, src_ready,
        input  busy, done, wf_phase, wf_phase_type, wf_data_in,
               pix_req, pix_addr, src_valid, src_data, frame_start, line_start
    );
endinterface

// File: rtl/waveform_sequencer.sv
// E-paper update sequencer: for each waveform phase, walks every pixel word of
// the frame through the waveform LUT and streams the drive bytes to the source driver.
module waveform_sequencer #(
    parameter int H_BYTES = 200,
    parameter int V_LINES = 600,
    parameter int AW      = 17
) (
    input  logic                clk,
    input  logic                reset,
    waveform_sequencer_if.master bus,
    output logic [2:0]          state_dbg_o
);
    localparam int CW = (H_BYTES > 1) ? $clog2(H_BYTES) : 1;
    localparam int LW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(H_BYTES - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        FETCH     = 3'd2,
        LOAD      = 3'd3,
        SEND      = 3'd4,
        LINE_END  = 3'd5,
        FRAME_END = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic          settle_q, settle_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [6:0]    phase_q, phase_d;
    logic [1:0]    ptype_q, ptype_d;
    logic [15:0]   data_in_q, data_in_d;
    logic [7:0]    src_data_q, src_data_d;
    logic          done_q, done_d;
    logic          fs_q, fs_d;
    logic          ls_q, ls_d;

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        col_d      = col_q;
        line_d     = line_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        ptype_d    = ptype_q;
        data_in_d  = data_in_q;
        src_data_d = src_data_q;
        done_d     = 1'b0;
        fs_d       = 1'b0;
        ls_d       = 1'b0;

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        ptype_d  = bus.phase_type;
                        phase_d  = '0;
                        col_d    = '0;
                        line_d   = '0;
                        addr_d   = '0;
                        settle_d = 1'b0;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (!settle_q) begin
                        settle_d = 1'b1;
                    end else begin
                        settle_d = 1'b0;
                        // A zero count also lands here, since any phase is >= 0.
                        if (phase_q >= bus.wf_phase_count) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            fs_d    = 1'b1;
                            ls_d    = 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (bus.pix_valid) begin
                        data_in_d = bus.pix_data;
                        state_d   = LOAD;
                    end
                end
                LOAD: begin
                    src_data_d = bus.wf_data_out;
                    state_d    = SEND;
                end
                SEND: begin
                    if (bus.src_ready) begin
                        addr_d = addr_q + 1'b1;
                        if (col_q != COL_LAST) begin
                            col_d   = col_q + 1'b1;
                            state_d = FETCH;
                        end else begin
                            col_d   = '0;
                            state_d = LINE_END;
                        end
                    end
                end
                LINE_END: begin
                    if (line_q != LINE_LAST) begin
                        line_d  = line_q + 1'b1;
                        ls_d    = 1'b1;
                        state_d = FETCH;
                    end else begin
                        line_d  = '0;
                        state_d = FRAME_END;
                    end
                end
                FRAME_END: begin
                    phase_d  = phase_q + 7'd1;
                    addr_d   = '0;
                    settle_d = 1'b0;
                    state_d  = SETTLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            settle_q   <= 1'b0;
            col_q      <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            phase_q    <= '0;
            ptype_q    <= '0;
            data_in_q  <= '0;
            src_data_q <= '0;
            done_q     <= 1'b0;
            fs_q       <= 1'b0;
            ls_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            col_q      <= col_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            ptype_q    <= ptype_d;
            data_in_q  <= data_in_d;
            src_data_q <= src_data_d;
            done_q     <= done_d;
            fs_q       <= fs_d;
            ls_q       <= ls_d;
        end
    end

    // Request/valid strobes follow the state directly so abort or reset drops them at once.
    assign bus.busy          = (state_q != IDLE);
    assign bus.pix_req       = (state_q == FETCH);
    assign bus.src_valid     = (state_q == SEND);
    assign bus.done          = done_q;
    assign bus.frame_start   = fs_q;
    assign bus.line_start    = ls_q;
    assign bus.wf_phase      = phase_q;
    assign bus.wf_phase_type = ptype_q;
    assign bus.wf_data_in    = data_in_q;
    assign bus.src_data      = src_data_q;
    assign bus.pix_addr      = addr_q;
    assign state_dbg_o       = state_q;
endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer with a 2x2-byte frame, a behavioural
// waveform LUT, and pixel/source responders with programmable wait states.
module tb_waveform_sequencer;
    localparam int AW = 17;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state_dbg;
    int         cyc = 0;

    waveform_sequencer_if #(.AW(AW)) bus ();

    waveform_sequencer #(.H_BYTES(2), .V_LINES(2), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int pix_delay, src_delay;
    int n_xfer, n_fs, n_ls, n_done, n_ov, n_preq, n_srcv, n_pw, n_sw, n_un;
    int done_cyc, last_xfer_cyc;
    logic [AW-1:0] addr_log[$];
    logic [6:0]    phase_log[$];
    logic [7:0]    exp_q[$];

    int b_xfer, b_fs, b_ls, b_done, b_ov, b_preq, b_srcv, b_pw, b_sw, b_un, b_addr, b_ph;

    function automatic logic [7:0] lut(input logic [15:0] d, input logic [6:0] ph, input logic [1:0] ty);
        return d[15:8] ^ {d[3:0], d[7:4]} ^ {ph[5:0], ty};
    endfunction

    function automatic logic [15:0] pix_word(input logic [AW-1:0] a, input logic [6:0] ph);
        return {a[7:0] ^ 8'h5A, 8'hC3 ^ {ph[3:0], a[3:0]}};
    endfunction

    assign bus.wf_data_out = lut(bus.wf_data_in, bus.wf_phase, bus.wf_phase_type);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pixel and source responders: each holds off for N cycles of a pending request.
    initial begin
        int pw = 0;
        int sw = 0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.src_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pix_req) begin
                if (pw == pix_delay) begin
                    bus.pix_valid = 1'b1;
                    bus.pix_data  = pix_word(bus.pix_addr, bus.wf_phase);
                    exp_q.push_back(lut(bus.pix_data, bus.wf_phase, bus.wf_phase_type));
                end else begin
                    bus.pix_valid = 1'b0;
                    pw++;
                end
            end else begin
                bus.pix_valid = 1'b0;
                pw = 0;
            end
            if (bus.src_valid) begin
                if (sw == src_delay) bus.src_ready = 1'b1;
                else begin
                    bus.src_ready = 1'b0;
                    sw++;
                end
            end else begin
                bus.src_ready = 1'b0;
                sw = 0;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    initial begin
        logic          p_req = 1'b0, p_val = 1'b0, s_val = 1'b0, s_rdy = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [7:0]    s_data = '0;
        forever begin
            @(negedge clk);
            if (reset || !bus.busy) exp_q.delete();
            if (!reset) begin
                if (bus.pix_req && bus.src_valid) n_ov++;
                if (bus.pix_req) begin
                    n_preq++;
                    if (!bus.pix_valid) n_pw++;
                end
                if (bus.src_valid) begin
                    n_srcv++;
                    if (!bus.src_ready) n_sw++;
                end
                if (bus.pix_req && p_req && !p_val && bus.pix_addr !== p_addr) n_un++;
                if (bus.src_valid && s_val && !s_rdy && bus.src_data !== s_data) n_un++;
                if (bus.pix_req && bus.pix_valid) addr_log.push_back(bus.pix_addr);
                if (bus.frame_start) begin
                    n_fs++;
                    phase_log.push_back(bus.wf_phase);
                end
                if (bus.line_start) n_ls++;
                if (bus.done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                if (bus.src_valid && bus.src_ready) begin
                    n_xfer++;
                    last_xfer_cyc = cyc;
                    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                    else check("src_data", 32'(bus.src_data), 32'(exp_q.pop_front()));
                end
            end
            p_req  = bus.pix_req;
            p_val  = bus.pix_valid;
            p_addr = bus.pix_addr;
            s_val  = bus.src_valid;
            s_rdy  = bus.src_ready;
            s_data = bus.src_data;
        end
    end

    task automatic snap();
        b_xfer = n_xfer; b_fs = n_fs; b_ls = n_ls; b_done = n_done; b_ov = n_ov;
        b_preq = n_preq; b_srcv = n_srcv; b_pw = n_pw; b_sw = n_sw; b_un = n_un;
        b_addr = addr_log.size(); b_ph = phase_log.size();
    endtask

    task automatic pulse_start(input logic [1:0] ty, output int s_cyc);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.phase_type = ty;
        s_cyc          = cyc;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.phase_type = 2'b00;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(bus.busy),          32'd0);
        check({tag, "_done"},      32'(bus.done),          32'd0);
        check({tag, "_pix_req"},   32'(bus.pix_req),       32'd0);
        check({tag, "_src_valid"}, 32'(bus.src_valid),     32'd0);
        check({tag, "_fs"},        32'(bus.frame_start),   32'd0);
        check({tag, "_ls"},        32'(bus.line_start),    32'd0);
        check({tag, "_phase"},     32'(bus.wf_phase),      32'd0);
        check({tag, "_ptype"},     32'(bus.wf_phase_type), 32'd0);
        check({tag, "_data_in"},   32'(bus.wf_data_in),    32'd0);
        check({tag, "_src_data"},  32'(bus.src_data),      32'd0);
        check({tag, "_addr"},      32'(bus.pix_addr),      32'd0);
        check({tag, "_state"},     32'(state_dbg),         32'd0);
    endtask

    initial begin
        int s, s2, n;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.phase_type = 2'b00;
        bus.wf_phase_count = 7'd0;
        pix_delay = 0;
        src_delay = 0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;

        // Three phases, no wait states; a busy-time start with type 01 is ignored.
        bus.wf_phase_count = 7'd3;
        snap();
        pulse_start(2'b10, s);
        n = 0;
        while (n_fs == b_fs && n < 100) begin
            @(negedge clk);
            n++;
        end
        pulse_start(2'b01, s2);
        check("ptype_held_busy", 32'(bus.wf_phase_type), 32'd2);
        wait_idle(400);
        check("a_xfers", 32'(n_xfer - b_xfer), 32'd12);
        check("a_frame_starts", 32'(n_fs - b_fs), 32'd3);
        check("a_line_starts", 32'(n_ls - b_ls), 32'd6);
        check("a_done", 32'(n_done - b_done), 32'd1);
        check("a_overlap", 32'(n_ov - b_ov), 32'd0);
        check("a_done_after_xfer", 32'(done_cyc - last_xfer_cyc), 32'd5);
        check("a_ptype_final", 32'(bus.wf_phase_type), 32'd2);
        check("a_addr_count", 32'(addr_log.size() - b_addr), 32'd12);
        for (int i = 0; i < 12 && b_addr + i < addr_log.size(); i++)
            check("a_addr", 32'(addr_log[b_addr + i]), 32'(i % 4));
        check("a_phase_count", 32'(phase_log.size() - b_ph), 32'd3);
        for (int i = 0; i < 3 && b_ph + i < phase_log.size(); i++)
            check("a_phase", 32'(phase_log[b_ph + i]), 32'(i));

        // Zero phase count: straight back to idle with done, no traffic.
        bus.wf_phase_count = 7'd0;
        snap();
        pulse_start(2'b00, s);
        wait_idle(50);
        check("b_done", 32'(n_done - b_done), 32'd1);
        check("b_done_latency", 32'(done_cyc - s), 32'd3);
        check("b_no_pix_req", 32'(n_preq - b_preq), 32'd0);
        check("b_no_src_valid", 32'(n_srcv - b_srcv), 32'd0);
        check("b_no_frame", 32'(n_fs - b_fs), 32'd0);

        // Wait states on both sides: payloads must hold while stalled.
        bus.wf_phase_count = 7'd1;
        pix_delay = 5;
        src_delay = 3;
        snap();
        pulse_start(2'b11, s);
        wait_idle(600);
        check("c_xfers", 32'(n_xfer - b_xfer), 32'd4);
        check("c_pix_wait_cycles", 32'(n_pw - b_pw), 32'd20);
        check("c_src_wait_cycles", 32'(n_sw - b_sw), 32'd12);
        check("c_stable", 32'(n_un - b_un), 32'd0);
        check("c_done", 32'(n_done - b_done), 32'd1);
        check("c_overlap", 32'(n_ov - b_ov), 32'd0);

        // Abort while the first byte of phase 1 waits in SEND.
        pix_delay = 0;
        src_delay = 2;
        bus.wf_phase_count = 7'd3;
        snap();
        pulse_start(2'b10, s);
        n = 0;
        while (!(bus.src_valid && bus.wf_phase == 7'd1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("d_reach_send", 32'(bus.src_valid), 32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("d_abort_state", 32'(state_dbg), 32'd0);
        check("d_abort_busy", 32'(bus.busy), 32'd0);
        check("d_abort_src_valid", 32'(bus.src_valid), 32'd0);
        check("d_abort_pix_req", 32'(bus.pix_req), 32'd0);
        repeat (5) @(negedge clk);
        check("d_no_done", 32'(n_done - b_done), 32'd0);
        check("d_xfers", 32'(n_xfer - b_xfer), 32'd4);
        src_delay = 0;
        bus.wf_phase_count = 7'd1;
        snap();
        pulse_start(2'b10, s);
        wait_idle(200);
        check("d_restart_done", 32'(n_done - b_done), 32'd1);
        check("d_restart_xfers", 32'(n_xfer - b_xfer), 32'd4);
        if (phase_log.size() > b_ph) check("d_restart_phase", 32'(phase_log[b_ph]), 32'd0);
        else check("d_restart_phase_missing", 32'(phase_log.size()), 32'(b_ph + 1));
        if (addr_log.size() > b_addr) check("d_restart_addr", 32'(addr_log[b_addr]), 32'd0);
        else check("d_restart_addr_missing", 32'(addr_log.size()), 32'(b_addr + 1));

        // Start and abort together in IDLE: nothing starts.
        snap();
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("e_start_abort_busy", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        check("e_start_abort_frames", 32'(n_fs - b_fs), 32'd0);

        // Asynchronous reset while phase 1 is fetching.
        pix_delay = 5;
        bus.wf_phase_count = 7'd3;
        pulse_start(2'b11, s);
        n = 0;
        while (!(bus.pix_req && bus.wf_phase == 7'd1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("f_reach_fetch", 32'(bus.pix_req), 32'd1);
        snap();
        reset = 1'b1;
        #1;
        check_all_zero("f_async");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("f_no_done", 32'(n_done - b_done), 32'd0);
        pix_delay = 0;
        bus.wf_phase_count = 7'd1;
        snap();
        pulse_start(2'b01, s);
        check("f_restart_busy", 32'(bus.busy), 32'd1);
        wait_idle(200);
        check("f_restart_done", 32'(n_done - b_done), 32'd1);
        check("f_restart_xfers", 32'(n_xfer - b_xfer), 32'd4);
        check("f_restart_ptype", 32'(bus.wf_phase_type), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
